// File: rtl/seq_divider_if.sv
// seq_divider_if: start/busy/done handshake plus operand and result buses
// of the sequential 8/4 restoring divider. The master issues divisions;
// the slave (the divider) performs them.
interface seq_divider_if;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       dbz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, 8-bit dividend by 4-bit divisor,
// one quotient bit per clock (8 RUN cycles, then a single DONE cycle).
// Optional build macro SEQ_DIVIDER_DBZ_EN: a zero divisor skips RUN, the
// result is produced in the cycle after acceptance and dbz is raised.
// Without the macro dbz is tied low and a zero divisor runs the full
// sequence, which yields the same quotient/remainder values.
module seq_divider (
  input  logic        clk,
  input  logic        rst_n,
  seq_divider_if.slave bus
);
  localparam int DATA_W = 8;
  localparam int COEF_W = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [2:0]          cnt;
  logic                accept;
  logic                zero_div;

  logic [DATA_W-1:0]   dvd_lat;
  logic [COEF_W-1:0]   dvs_lat;
  logic [COEF_W:0]     r_work;
  logic [DATA_W-1:0]   q_work;

  logic [COEF_W:0]     r_step;
  logic                q_bit;
  logic [DATA_W-1:0]   q_step;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits. Returns {qbit, R}.
  function automatic logic [COEF_W+1:0] restore_step(
    input logic [COEF_W:0]   r,
    input logic              in_bit,
    input logic [COEF_W-1:0] d
  );
    logic [COEF_W:0] sh;
    sh = {r[COEF_W-1:0], in_bit};
    if (sh >= {1'b0, d})
      return {1'b1, sh - {1'b0, d}};
    else
      return {1'b0, sh};
  endfunction

  // Start is honoured only when no division is in flight.
  assign accept = bus.start && ((state == IDLE) || (state == DONE));

`ifdef SEQ_DIVIDER_DBZ_EN
  assign zero_div = accept && (bus.divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  // Combinational iteration: next partial remainder and quotient for bit cnt.
  always_comb begin
    {q_bit, r_step} = restore_step(r_work, dvd_lat[cnt], dvs_lat);
    q_step          = q_work;
    q_step[cnt]     = q_bit;
  end

  // State register and iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        cnt <= 3'd7;
      else if (state == RUN)
        cnt <= cnt - 3'd1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = zero_div ? DONE : RUN;
      RUN:     if (cnt == 3'd0) state_nxt = DONE;
      DONE:    if (accept) state_nxt = zero_div ? DONE : RUN;
               else        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  // ---- Stage boundary: operand capture and iterative working registers ----
  // Working registers: operands latched on accept, updated every RUN cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd_lat <= bus.dividend;
      dvs_lat <= bus.divisor;
      r_work  <= '0;
      q_work  <= '0;
    end else if (state == RUN) begin
      r_work  <= r_step;
      q_work  <= q_step;
    end
  end

  // ---- Stage boundary: result registers, loaded only on entry to DONE ----
  // Result registers: last iteration's values, or the divide-by-zero result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.quotient  <= '0;
      bus.remainder <= '0;
`ifdef SEQ_DIVIDER_DBZ_EN
      bus.dbz       <= 1'b0;
`endif
    end else if ((state == RUN) && (cnt == 3'd0)) begin
      bus.quotient  <= q_step;
      bus.remainder <= r_step[COEF_W-1:0];
`ifdef SEQ_DIVIDER_DBZ_EN
      bus.dbz       <= 1'b0;
`endif
    end else if (zero_div) begin
      bus.quotient  <= '1;
      bus.remainder <= bus.dividend[COEF_W-1:0];
`ifdef SEQ_DIVIDER_DBZ_EN
      bus.dbz       <= 1'b1;
`endif
    end
  end

`ifndef SEQ_DIVIDER_DBZ_EN
  assign bus.dbz = 1'b0;
`endif

endmodule
